reaction_round_ctrl: RTL and testbench
======================================

Name: reaction_round_ctrl

Overview:
Multi-round reaction-time game controller. It is the parametrised successor to the single-shot start/play/end game sequencer.
- Runs ROUNDS rounds. Each round waits a pseudo-random delay, raises a prompt, and measures the ms until the player reacts.
- Detects false starts and timeouts, and keeps last, best and total reaction time.
- Drives the screen-select and score-display logic; contains no pixel rendering.

Parameters:
ROUNDS, 3, rounds per game (1..15)
TICK_DIV, 100000, clk cycles per 1 ms tick
MIN_DELAY_MS, 1000, minimum arm delay in ms
DELAY_MASK_W, 11, LFSR bits added to the delay; random span 0..2^DELAY_MASK_W-1 ms
TIMEOUT_MS, 3000, reaction limit in ms
HOLD_MS, 500, result display hold in ms
TIME_W, 12, time field width; must hold TIMEOUT_MS and MIN_DELAY_MS+2^DELAY_MASK_W-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous pulse; begins a game from IDLE or DONE
abort  in  1  synchronous level; forces IDLE from any state
react  in  1  raw player button, asynchronous
seed_load  in  1  load seed into the LFSR; honoured in IDLE only
seed  in  16  LFSR seed
state  out  3  IDLE=0, ARM=1, PROMPT=2, RESULT=3, DONE=4
prompt  out  1  high throughout PROMPT
round_idx  out  4  current round, 0-based
result_valid  out  1  one-cycle pulse on entering RESULT
result_code  out  2  HIT=0, FALSE_START=1, TIMEOUT=2; held until the next result
last_time  out  TIME_W  ms of the latest result
best_time  out  TIME_W  minimum HIT time; all-ones if no HIT yet
sum_time  out  TIME_W+4  sum of last_time over completed rounds
false_cnt  out  4  false starts this game, saturating at 15
done  out  1  high in DONE

Behaviour:
Reset values:
- state=IDLE, all counters 0, outputs 0, best_time all-ones, LFSR=16'hACE1.

React input:
- Passes through two synchronising flops, then a rising-edge detector (sync2 & ~sync3).
- React edge is seen by the FSM 3 cycles after react rises. Only edges count; holding the button counts once.

LFSR:
- 16-bit Galois, taps mask 16'hB400, shifts every clk cycle.
- seed_load in IDLE loads seed; seed of 0 loads 16'hACE1.

Ms tick:
- Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap.
- Cleared on every state entry, so the first tick arrives TICK_DIV cycles after entry.

FSM:
- IDLE: start clears round_idx, sum_time, false_cnt and best_time (to all-ones), then goes to ARM.
- ARM, on entry: delay = MIN_DELAY_MS + LFSR[DELAY_MASK_W-1:0] sampled that cycle; ms counter cleared.
  - React edge: FALSE_START, last_time=0, false_cnt++, round_idx unchanged (round is retried) → RESULT.
  - ms counter == delay: → PROMPT. A react edge in the same cycle counts as FALSE_START.
- PROMPT, on entry: ms counter cleared; prompt=1.
  - React edge: HIT, last_time=ms count, sum_time+=last_time, best_time=min(best_time, last_time) → RESULT.
  - ms count reaches TIMEOUT_MS: TIMEOUT, last_time=TIMEOUT_MS, sum_time+=TIMEOUT_MS → RESULT.
  - React edge coinciding with the timeout tick: HIT with time TIMEOUT_MS.
- RESULT: result_valid pulses on the entry cycle. After HOLD_MS ticks:
  - FALSE_START → ARM, same round.
  - Otherwise, if round_idx==ROUNDS-1 → DONE; else round_idx++ → ARM.
- DONE: all results held; start → new game, same as from IDLE.

Abort and start rules:
- abort has priority over every transition: → IDLE next cycle; score outputs keep their values; prompt drops.
- start outside IDLE/DONE is ignored.

Arithmetic:
- The ms counter saturates at its all-ones value.
- sum_time is TIME_W+4 bits; it cannot overflow for ROUNDS≤15.

Reset mid-game:
- Immediate IDLE with reset values; no result_valid pulse.

Test Plan:
Bench parameters: TICK_DIV=4, MIN_DELAY_MS=2, DELAY_MASK_W=2, TIMEOUT_MS=10, HOLD_MS=1, ROUNDS=3.
- Seed 16'h0001 loaded, start, react 5 ms after prompt rises (within sync latency) → result_valid with HIT, last_time=5, best_time=5, sum_time=5, round_idx=1 after hold.
- Three HIT rounds at 7, 3 and 9 ms → best_time=3, sum_time=19, done=1, state=4.
- React pulse during ARM → FALSE_START, last_time=0, false_cnt=1, round_idx unchanged, next state ARM.
- No react in PROMPT → TIMEOUT after 10 ticks (40 cycles post-entry), last_time=10, best_time stays all-ones.
- abort asserted in PROMPT → state=IDLE next cycle, prompt=0; subsequent start resets sum_time=0, round_idx=0.
- seed 0 loaded, then rst_n pulsed low mid-ARM → LFSR=16'hACE1, state=IDLE asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-time game sequencer: random arm delay, prompt, ms reaction timing, scoring.
// React edges act 3 cycles after the button rises; no handshakes, all outputs are registered levels/pulses.
module reaction_round_ctrl #(
   parameter int ROUNDS       = 3,
   parameter int TICK_DIV     = 100000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int DELAY_MASK_W = 11,
   parameter int TIMEOUT_MS   = 3000,
   parameter int HOLD_MS      = 500,
   parameter int TIME_W       = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              react,
   input  logic              seed_load,
   input  logic [15:0]       seed,
   output logic [2:0]        state,
   output logic              prompt,
   output logic [3:0]        round_idx,
   output logic              result_valid,
   output logic [1:0]        result_code,
   output logic [TIME_W-1:0] last_time,
   output logic [TIME_W-1:0] best_time,
   output logic [TIME_W+3:0] sum_time,
   output logic [3:0]        false_cnt,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_PROMPT = 3'd2,
      S_RESULT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [1:0]        RC_HIT     = 2'd0;
   localparam logic [1:0]        RC_FALSE   = 2'd1;
   localparam logic [1:0]        RC_TIMEOUT = 2'd2;
   localparam int                PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [15:0]       LFSR_INIT  = 16'hACE1;
   localparam logic [15:0]       LFSR_TAPS  = 16'hB400;
   localparam logic [TIME_W-1:0] TIME_MAX   = '1;
   localparam logic [TIME_W-1:0] T_TIMEOUT  = TIME_W'(TIMEOUT_MS);
   localparam logic [TIME_W-1:0] T_HOLD     = TIME_W'(HOLD_MS);
   localparam logic [TIME_W-1:0] T_MIN      = TIME_W'(MIN_DELAY_MS);

   state_t            st, st_nxt;
   logic [2:0]        sync_q;
   logic              react_edge;
   logic [15:0]       lfsr;
   logic [PW-1:0]     presc;
   logic              tick;
   logic              entering;
   logic [TIME_W-1:0] ms_cnt, ms_now, delay_ms;
   logic              res_en, new_game, round_inc;
   logic [1:0]        res_code_d;
   logic [TIME_W-1:0] res_time_d;

   assign react_edge = sync_q[1] & ~sync_q[2];
   assign tick       = (presc == PW'(TICK_DIV - 1));
   // ms_now is the count including a tick landing this cycle, so decisions see the up-to-date time.
   assign ms_now     = (tick && ms_cnt != TIME_MAX) ? ms_cnt + 1'b1 : ms_cnt;
   assign entering   = (st_nxt != st);
   assign state      = st;
   assign prompt     = (st == S_PROMPT);
   assign done       = (st == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         lfsr   <= LFSR_INIT;
      end else begin
         sync_q <= {sync_q[1:0], react};
         if (st == S_IDLE && seed_load)
            lfsr <= (seed == 16'd0) ? LFSR_INIT : seed;
         else
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      end
   end

   always_comb begin
      st_nxt     = st;
      res_en     = 1'b0;
      res_code_d = RC_HIT;
      res_time_d = '0;
      new_game   = 1'b0;
      round_inc  = 1'b0;
      if (abort) begin
         st_nxt = S_IDLE;
      end else begin
         unique case (st)
            S_IDLE, S_DONE: begin
               if (start) begin
                  new_game = 1'b1;
                  st_nxt   = S_ARM;
               end
            end
            S_ARM: begin
               if (react_edge) begin
                  res_en     = 1'b1;
                  res_code_d = RC_FALSE;
                  st_nxt     = S_RESULT;
               end else if (ms_now >= delay_ms) begin
                  st_nxt = S_PROMPT;
               end
            end
            S_PROMPT: begin
               // A press on the timeout tick still wins as a HIT at the limit time.
               if (react_edge) begin
                  res_en     = 1'b1;
                  res_code_d = RC_HIT;
                  res_time_d = ms_now;
                  st_nxt     = S_RESULT;
               end else if (ms_now >= T_TIMEOUT) begin
                  res_en     = 1'b1;
                  res_code_d = RC_TIMEOUT;
                  res_time_d = T_TIMEOUT;
                  st_nxt     = S_RESULT;
               end
            end
            S_RESULT: begin
               if (ms_now >= T_HOLD) begin
                  if (result_code == RC_FALSE) begin
                     st_nxt = S_ARM;
                  end else if (round_idx == 4'(ROUNDS - 1)) begin
                     st_nxt = S_DONE;
                  end else begin
                     round_inc = 1'b1;
                     st_nxt    = S_ARM;
                  end
               end
            end
            default: st_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= S_IDLE;
         presc    <= '0;
         ms_cnt   <= '0;
         delay_ms <= '0;
      end else begin
         st       <= st_nxt;
         presc    <= (entering || tick) ? '0 : presc + 1'b1;
         ms_cnt   <= entering ? '0 : ms_now;
         if (entering && st_nxt == S_ARM)
            delay_ms <= T_MIN + TIME_W'(lfsr[DELAY_MASK_W-1:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_valid <= 1'b0;
         result_code  <= RC_HIT;
         last_time    <= '0;
         best_time    <= '1;
         sum_time     <= '0;
         false_cnt    <= '0;
         round_idx    <= '0;
      end else begin
         result_valid <= res_en;
         if (new_game) begin
            round_idx <= '0;
            sum_time  <= '0;
            false_cnt <= '0;
            best_time <= '1;
         end
         if (round_inc)
            round_idx <= round_idx + 1'b1;
         if (res_en) begin
            result_code <= res_code_d;
            last_time   <= res_time_d;
            if (res_code_d == RC_FALSE) begin
               if (false_cnt != 4'hF)
                  false_cnt <= false_cnt + 1'b1;
            end else begin
               sum_time <= sum_time + (TIME_W+4)'(res_time_d);
               if (res_code_d == RC_HIT && res_time_d < best_time)
                  best_time <= res_time_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: per-cycle comparison against a cycles-since-entry game model,
// plus hand-computed checkpoints for hits, false start, timeout, abort and mid-game reset.
module tb_reaction_round_ctrl;
   localparam int ROUNDS       = 3;
   localparam int TICK_DIV     = 4;
   localparam int MIN_DELAY_MS = 2;
   localparam int DELAY_MASK_W = 2;
   localparam int TIMEOUT_MS   = 10;
   localparam int HOLD_MS      = 1;
   localparam int TIME_W       = 12;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        start = 1'b0, abort = 1'b0, react = 1'b0, seed_load = 1'b0;
   logic [15:0] seed = 16'd0;
   logic [2:0]  state;
   logic        prompt, result_valid, done;
   logic [3:0]  round_idx, false_cnt;
   logic [1:0]  result_code;
   logic [TIME_W-1:0] last_time, best_time;
   logic [TIME_W+3:0] sum_time;

   int n_cmp = 0;
   int n_bad = 0;

   reaction_round_ctrl #(
      .ROUNDS(ROUNDS), .TICK_DIV(TICK_DIV), .MIN_DELAY_MS(MIN_DELAY_MS),
      .DELAY_MASK_W(DELAY_MASK_W), .TIMEOUT_MS(TIMEOUT_MS), .HOLD_MS(HOLD_MS), .TIME_W(TIME_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .react(react),
      .seed_load(seed_load), .seed(seed), .state(state), .prompt(prompt),
      .round_idx(round_idx), .result_valid(result_valid), .result_code(result_code),
      .last_time(last_time), .best_time(best_time), .sum_time(sum_time),
      .false_cnt(false_cnt), .done(done)
   );

   always #5 clk = ~clk;

   // Game model: time in a state is tracked as raw cycles since entry; ms = completed cycles / TICK_DIV.
   typedef struct packed {
      logic [2:0]  st;
      int          age;
      int          rnd;
      logic        rv;
      int          code;
      int          last;
      int          best;
      int          sum;
      int          fcnt;
      int          delay;
      logic [15:0] lfsr;
      logic [2:0]  h;
   } model_t;

   model_t m;

   function automatic logic [15:0] galois(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic model_t m_reset();
      model_t r;
      r      = '0;
      r.best = (1 << TIME_W) - 1;
      r.lfsr = 16'hACE1;
      return r;
   endfunction

   function automatic model_t step(input model_t c, input logic st_i, input logic ab_i,
                                   input logic re_i, input logic sl_i, input logic [15:0] sd_i);
      model_t n;
      int     ms;
      int     nxt;
      logic   pressed;
      n       = c;
      ms      = (c.age + 1) / TICK_DIV;
      pressed = c.h[1] & ~c.h[2];
      n.rv    = 1'b0;
      n.h     = {c.h[1:0], re_i};
      n.lfsr  = (c.st == 3'd0 && sl_i) ? ((sd_i == 16'd0) ? 16'hACE1 : sd_i) : galois(c.lfsr);
      nxt     = int'(c.st);
      if (ab_i) nxt = 0;
      else begin
         case (c.st)
            3'd0, 3'd4: if (st_i) begin
               n.rnd = 0; n.sum = 0; n.fcnt = 0; n.best = (1 << TIME_W) - 1; nxt = 1;
            end
            3'd1: if (pressed) begin
               n.code = 1; n.last = 0; n.rv = 1'b1; nxt = 3;
               if (c.fcnt < 15) n.fcnt = c.fcnt + 1;
            end else if (ms >= c.delay) nxt = 2;
            3'd2: if (pressed) begin
               n.code = 0; n.last = ms; n.sum = c.sum + ms; n.rv = 1'b1; nxt = 3;
               if (ms < c.best) n.best = ms;
            end else if (ms >= TIMEOUT_MS) begin
               n.code = 2; n.last = TIMEOUT_MS; n.sum = c.sum + TIMEOUT_MS; n.rv = 1'b1; nxt = 3;
            end
            3'd3: if (ms >= HOLD_MS) begin
               if (c.code == 1) nxt = 1;
               else if (c.rnd == ROUNDS - 1) nxt = 4;
               else begin n.rnd = c.rnd + 1; nxt = 1; end
            end
            default: nxt = 0;
         endcase
      end
      if (nxt == 1 && c.st != 3'd1)
         n.delay = MIN_DELAY_MS + (int'(c.lfsr) % (1 << DELAY_MASK_W));
      n.age = (nxt == int'(c.st)) ? c.age + 1 : 0;
      n.st  = 3'(nxt);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= m_reset();
      else        m <= step(m, start, abort, react, seed_load, seed);
   end

   logic [55:0] act_v, exp_v;
   always @(negedge clk) begin
      act_v = {state, prompt, round_idx, result_valid, result_code, last_time, best_time,
               sum_time, false_cnt, done};
      exp_v = {m.st, (m.st == 3'd2), 4'(m.rnd), m.rv, 2'(m.code), 12'(m.last), 12'(m.best),
               16'(m.sum), 4'(m.fcnt), (m.st == 3'd4)};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, act_v, exp_v);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic timed_out(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s wait expired", nm);
   endtask

   task automatic wait_prompt();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (prompt) return;
      end
      timed_out("wait_prompt");
   endtask

   task automatic wait_rv();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (result_valid) return;
      end
      timed_out("wait_result_valid");
   endtask

   task automatic wait_state(input logic [2:0] s);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state == s) return;
      end
      timed_out("wait_state");
   endtask

   // Called at the first PROMPT cycle; press lands so the measured time is exactly t ms.
   task automatic hit(input int t);
      repeat (4 * t - 2) @(negedge clk);
      react = 1'b1;
      repeat (2) @(negedge clk);
      react = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int hits[3] = '{7, 3, 9};

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_best", 32'(best_time), 32'hFFF);
      check("reset_sum", 32'(sum_time), 32'd0);
      check("reset_lfsr", 32'(dut.lfsr), 32'hACE1);
      rst_n = 1'b1;
      @(negedge clk);

      // Game 1: seed 1, hit at 5 ms, false start, then abort in PROMPT.
      seed = 16'h0001; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      check("seed_loaded", 32'(dut.lfsr), 32'h0001);
      pulse_start();
      check("start_to_arm", 32'(state), 32'd1);
      wait_prompt();
      hit(5);
      wait_rv();
      check("hit5_code", 32'(result_code), 32'd0);
      check("hit5_last", 32'(last_time), 32'd5);
      check("hit5_best", 32'(best_time), 32'd5);
      check("hit5_sum", 32'(sum_time), 32'd5);
      repeat (4) @(negedge clk);
      check("hit5_round_next", 32'(round_idx), 32'd1);
      check("hit5_state_arm", 32'(state), 32'd1);

      react = 1'b1;
      repeat (2) @(negedge clk);
      react = 1'b0;
      wait_rv();
      check("fs_code", 32'(result_code), 32'd1);
      check("fs_last", 32'(last_time), 32'd0);
      check("fs_cnt", 32'(false_cnt), 32'd1);
      check("fs_round", 32'(round_idx), 32'd1);
      repeat (4) @(negedge clk);
      check("fs_next_arm", 32'(state), 32'd1);
      check("fs_round_kept", 32'(round_idx), 32'd1);

      wait_prompt();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_state", 32'(state), 32'd0);
      check("abort_prompt", 32'(prompt), 32'd0);
      check("abort_sum_kept", 32'(sum_time), 32'd5);

      // Game 2: three hits at 7, 3, 9 ms.
      pulse_start();
      check("restart_round", 32'(round_idx), 32'd0);
      check("restart_sum", 32'(sum_time), 32'd0);
      check("restart_fcnt", 32'(false_cnt), 32'd0);
      foreach (hits[i]) begin
         wait_prompt();
         hit(hits[i]);
         wait_rv();
         check("hit_last", 32'(last_time), 32'(hits[i]));
      end
      repeat (4) @(negedge clk);
      check("game_done", 32'(done), 32'd1);
      check("game_state", 32'(state), 32'd4);
      check("game_best", 32'(best_time), 32'd3);
      check("game_sum", 32'(sum_time), 32'd19);

      // Game 3 from DONE: timeout exactly 40 cycles after prompt entry.
      pulse_start();
      check("done_restart_best", 32'(best_time), 32'hFFF);
      wait_prompt();
      repeat (39) @(negedge clk);
      check("to_still_prompt", 32'(state), 32'd2);
      @(negedge clk);
      check("to_state", 32'(state), 32'd3);
      check("to_rv", 32'(result_valid), 32'd1);
      check("to_code", 32'(result_code), 32'd2);
      check("to_last", 32'(last_time), 32'd10);
      check("to_best", 32'(best_time), 32'hFFF);
      check("to_sum", 32'(sum_time), 32'd10);

      // Abort, zero seed, then reset in the middle of ARM.
      wait_state(3'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      seed = 16'h0000; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      check("seed0_lfsr", 32'(dut.lfsr), 32'hACE1);
      pulse_start();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_lfsr", 32'(dut.lfsr), 32'hACE1);
      check("arst_sum", 32'(sum_time), 32'd0);
      check("arst_best", 32'(best_time), 32'hFFF);
      check("arst_last", 32'(last_time), 32'd0);
      check("arst_rv", 32'(result_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
